// File: rtl/stack_unit_if.sv
// stack_unit_if: request/response bundle between the control unit and the
// hardware stack.
//   push_req  (CU -> stack)  push request, level, held until push_done
//   pop_req   (CU -> stack)  pop request, level, held until pop_done
//   push_data (CU -> stack)  word to push, sampled when the request is accepted
//   push_done (stack -> CU)  one-cycle pulse, push finished
//   pop_done  (stack -> CU)  one-cycle pulse, pop finished, pop_out valid
//   pop_out   (stack -> CU)  last popped word, held until the next good pop
interface stack_unit_if #(
  parameter int DATA_W = 16
);
  logic              push_req;
  logic              pop_req;
  logic [DATA_W-1:0] push_data;
  logic              push_done;
  logic              pop_done;
  logic [DATA_W-1:0] pop_out;

  modport master (
    output push_req, pop_req, push_data,
    input  push_done, pop_done, pop_out
  );

  modport slave (
    input  push_req, pop_req, push_data,
    output push_done, pop_done, pop_out
  );
endinterface

// File: rtl/stack_unit.sv
// stack_unit: LIFO stack that answers CU push/pop requests with a one-cycle
// done pulse per accepted request.
//   clk      system clock, rising edge
//   rst_b    asynchronous active-low reset
//   bus      stack_unit_if.slave (push_req/pop_req/push_data in,
//            push_done/pop_done/pop_out out)
//   sp       entry count, 0 = empty, DEPTH = full
//   empty    sp == 0
//   full     sp == DEPTH
//   ovf_err  sticky, push attempted while full
//   unf_err  sticky, pop attempted while empty
//   err_clr  synchronous clear of both sticky flags (a new error wins)
module stack_unit #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int SP_W   = 7
) (
  input  logic             clk,
  input  logic             rst_b,
  stack_unit_if.slave      bus,
  output logic [SP_W-1:0]  sp,
  output logic             empty,
  output logic             full,
  output logic             ovf_err,
  output logic             unf_err,
  input  logic             err_clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0] DEPTH_C   = SP_W'(DEPTH);
  localparam logic [SP_W-1:0] SP_ZERO_C = {SP_W{1'b0}};
  localparam logic [SP_W-1:0] SP_ONE_C  = {{(SP_W-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]   AD_ONE_C  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PUSH = 2'd1,
    ST_POP  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  state_e            state_r;
  state_e            state_nxt_s;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] pop_out_r;
  logic [SP_W-1:0]   sp_r;
  logic              push_done_r;
  logic              pop_done_r;
  logic              ovf_err_r;
  logic              unf_err_r;

  logic              can_push_s;
  logic              can_pop_s;
  logic              ovf_set_s;
  logic              unf_set_s;
  logic [AW-1:0]     wr_addr_s;
  logic [AW-1:0]     rd_addr_s;

  assign can_push_s = (sp_r != DEPTH_C);
  assign can_pop_s  = (sp_r != SP_ZERO_C);
  assign ovf_set_s  = (state_r == ST_PUSH) && !can_push_s;
  assign unf_set_s  = (state_r == ST_POP) && !can_pop_s;

  // Top of stack lives at sp-1; at sp == DEPTH the truncated write address
  // wraps to 0 but the write is blocked, while the read address lands on
  // DEPTH-1 as required.
  assign wr_addr_s  = sp_r[AW-1:0];
  assign rd_addr_s  = wr_addr_s - AD_ONE_C;

  // FSM state register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: push wins over pop, HOLD waits for both requests to drop
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.push_req) begin
          state_nxt_s = ST_PUSH;
        end else if (bus.pop_req) begin
          state_nxt_s = ST_POP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PUSH: state_nxt_s = ST_HOLD;
      ST_POP:  state_nxt_s = ST_HOLD;
      ST_HOLD: begin
        if (bus.push_req || bus.pop_req) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Latch the push word at acceptance so later push_data changes are ignored
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      data_r <= {DATA_W{1'b0}};
    end else if ((state_r == ST_IDLE) && bus.push_req) begin
      data_r <= bus.push_data;
    end
  end

  // Stack storage write port (contents are not reset)
  always_ff @(posedge clk) begin
    if ((state_r == ST_PUSH) && can_push_s) begin
      mem_r[wr_addr_s] <= data_r;
    end
  end

  // Stack pointer and popped word; blocked operations leave both untouched
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sp_r      <= SP_ZERO_C;
      pop_out_r <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_PUSH: begin
          if (can_push_s) begin
            sp_r <= sp_r + SP_ONE_C;
          end
        end
        ST_POP: begin
          if (can_pop_s) begin
            pop_out_r <= mem_r[rd_addr_s];
            sp_r      <= sp_r - SP_ONE_C;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Done pulses: high for exactly the cycle after PUSH or POP
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      push_done_r <= 1'b0;
      pop_done_r  <= 1'b0;
    end else begin
      push_done_r <= (state_r == ST_PUSH);
      pop_done_r  <= (state_r == ST_POP);
    end
  end

  // Sticky error flags; a new error in the same cycle beats err_clr
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ovf_err_r <= 1'b0;
      unf_err_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        ovf_err_r <= 1'b1;
      end else if (err_clr) begin
        ovf_err_r <= 1'b0;
      end
      if (unf_set_s) begin
        unf_err_r <= 1'b1;
      end else if (err_clr) begin
        unf_err_r <= 1'b0;
      end
    end
  end

  assign bus.push_done = push_done_r;
  assign bus.pop_done  = pop_done_r;
  assign bus.pop_out   = pop_out_r;
  assign sp            = sp_r;
  assign empty         = (sp_r == SP_ZERO_C);
  assign full          = (sp_r == DEPTH_C);
  assign ovf_err       = ovf_err_r;
  assign unf_err       = unf_err_r;

endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed and randomized checks of stack_unit against a
// queue-based LIFO reference model.
module tb_stack_unit;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 64;
  localparam int SP_W   = 7;

  logic            clk = 1'b0;
  logic            rst_b = 1'b0;
  logic            err_clr = 1'b0;
  logic [SP_W-1:0] sp;
  logic            empty, full, ovf_err, unf_err;

  stack_unit_if #(.DATA_W(DATA_W)) bus ();

  stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SP_W(SP_W)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .bus     (bus),
    .sp      (sp),
    .empty   (empty),
    .full    (full),
    .ovf_err (ovf_err),
    .unf_err (unf_err),
    .err_clr (err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [DATA_W-1:0] m_q[$];
  bit                m_ovf, m_unf;
  logic [DATA_W-1:0] m_pop_out;

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_pop_out = '0;
  endtask

  // one accepted request; clr is held for the whole request so any error of
  // this request survives it
  task automatic model_apply(input bit push, input bit pop, input logic [DATA_W-1:0] d, input bit clr);
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(d);
      else m_ovf = 1'b1;
    end else if (pop) begin
      if (m_q.size() > 0) m_pop_out = m_q.pop_back();
      else m_unf = 1'b1;
    end
  endtask

  // drive one request, wait (bounded) for its done, drop it; lat = cycles
  // from first sampling edge to done visible, stuck = done still high a cycle later
  task automatic run_op(input bit push, input bit pop, input logic [DATA_W-1:0] d, input bit clr,
                        output int lat, output bit got_push, output bit got_pop, output bit stuck);
    @(negedge clk);
    bus.push_req = push;
    bus.pop_req = pop;
    bus.push_data = d;
    err_clr = clr;
    lat = 0;
    got_push = 1'b0;
    got_pop = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) bus.push_data = ~d;
      if (bus.push_done || bus.pop_done) begin
        lat = i;
        got_push = bus.push_done;
        got_pop = bus.pop_done;
        break;
      end
    end
    bus.push_req = 1'b0;
    bus.pop_req = 1'b0;
    bus.push_data = DATA_W'($urandom);
    err_clr = 1'b0;
    @(posedge clk);
    #1;
    stuck = bus.push_done | bus.pop_done;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.push_req = 1'b0;
    bus.pop_req = 1'b0;
    bus.push_data = '0;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    checks++; if (sp !== 7'd0) begin errors++; $display("FAIL reset_sp got %0d exp 0", sp); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_empty_full got %b%b exp 10", empty, full); end
    checks++; if (ovf_err !== 1'b0 || unf_err !== 1'b0) begin errors++; $display("FAIL reset_errs got %b%b exp 00", ovf_err, unf_err); end
    checks++; if (bus.pop_out !== 16'h0000) begin errors++; $display("FAIL reset_pop_out got %h exp 0000", bus.pop_out); end
    checks++; if (bus.push_done !== 1'b0 || bus.pop_done !== 1'b0) begin errors++; $display("FAIL reset_dones got %b%b exp 00", bus.push_done, bus.pop_done); end
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_basic();
    int lat; bit gp, go, st;
    logic [DATA_W-1:0] vals [2];
    vals[0] = 16'h1234;
    vals[1] = 16'hBEEF;
    for (int i = 0; i < 2; i++) begin
      run_op(1'b1, 1'b0, vals[i], 1'b0, lat, gp, go, st);
      model_apply(1'b1, 1'b0, vals[i], 1'b0);
      checks++; if (lat !== 2 || gp !== 1'b1 || go !== 1'b0 || st !== 1'b0) begin
        errors++; $display("FAIL basic_push_pulse got lat=%0d push=%b pop=%b stuck=%b exp lat=2 push=1 pop=0 stuck=0", lat, gp, go, st);
      end
    end
    checks++; if (sp !== 7'd2 || empty !== 1'b0) begin errors++; $display("FAIL basic_sp2 got sp=%0d empty=%b exp sp=2 empty=0", sp, empty); end
    for (int i = 0; i < 2; i++) begin
      run_op(1'b0, 1'b1, '0, 1'b0, lat, gp, go, st);
      model_apply(1'b0, 1'b1, '0, 1'b0);
      checks++; if (bus.pop_out !== m_pop_out) begin errors++; $display("FAIL basic_pop_data got %h exp %h", bus.pop_out, m_pop_out); end
      checks++; if (lat !== 2 || gp !== 1'b0 || go !== 1'b1 || st !== 1'b0) begin
        errors++; $display("FAIL basic_pop_pulse got lat=%0d push=%b pop=%b stuck=%b exp lat=2 push=0 pop=1 stuck=0", lat, gp, go, st);
      end
    end
    checks++; if (sp !== 7'd0 || empty !== 1'b1) begin errors++; $display("FAIL basic_sp0 got sp=%0d empty=%b exp sp=0 empty=1", sp, empty); end
  endtask

  task automatic test_underflow();
    int lat; bit gp, go, st;
    run_op(1'b0, 1'b1, '0, 1'b0, lat, gp, go, st);
    model_apply(1'b0, 1'b1, '0, 1'b0);
    checks++; if (go !== 1'b1 || lat !== 2) begin errors++; $display("FAIL unf_done got pop=%b lat=%0d exp pop=1 lat=2", go, lat); end
    checks++; if (bus.pop_out !== 16'h1234 || sp !== 7'd0) begin errors++; $display("FAIL unf_hold got pop_out=%h sp=%0d exp pop_out=1234 sp=0", bus.pop_out, sp); end
    checks++; if (unf_err !== 1'b1 || ovf_err !== 1'b0) begin errors++; $display("FAIL unf_flag got unf=%b ovf=%b exp unf=1 ovf=0", unf_err, ovf_err); end
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    m_unf = 1'b0;
    checks++; if (unf_err !== 1'b0) begin errors++; $display("FAIL unf_clear got %b exp 0", unf_err); end
    // err_clr held across an underflowing pop: the new error must win
    run_op(1'b0, 1'b1, '0, 1'b1, lat, gp, go, st);
    model_apply(1'b0, 1'b1, '0, 1'b1);
    checks++; if (unf_err !== 1'b1) begin errors++; $display("FAIL unf_set_wins got %b exp 1", unf_err); end
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    m_unf = 1'b0;
    checks++; if (unf_err !== m_unf) begin errors++; $display("FAIL unf_clear2 got %b exp %b", unf_err, m_unf); end
  endtask

  task automatic test_fill_overflow();
    int lat; bit gp, go, st;
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      run_op(1'b1, 1'b0, DATA_W'(i), 1'b0, lat, gp, go, st);
      model_apply(1'b1, 1'b0, DATA_W'(i), 1'b0);
      if (lat != 2 || gp != 1'b1 || st != 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL fill_pulses got %0d bad exp 0", bad); end
    checks++; if (full !== 1'b1 || ovf_err !== 1'b0 || sp !== 7'd64) begin errors++; $display("FAIL fill_full got full=%b ovf=%b sp=%0d exp 1 0 64", full, ovf_err, sp); end
    run_op(1'b1, 1'b0, 16'hAAAA, 1'b0, lat, gp, go, st);
    model_apply(1'b1, 1'b0, 16'hAAAA, 1'b0);
    checks++; if (gp !== 1'b1 || full !== 1'b1 || ovf_err !== 1'b1 || sp !== 7'd64) begin
      errors++; $display("FAIL ovf got done=%b full=%b ovf=%b sp=%0d exp 1 1 1 64", gp, full, ovf_err, sp);
    end
    run_op(1'b0, 1'b1, '0, 1'b0, lat, gp, go, st);
    model_apply(1'b0, 1'b1, '0, 1'b0);
    checks++; if (bus.pop_out !== 16'd63 || sp !== 7'd63 || full !== 1'b0) begin
      errors++; $display("FAIL ovf_pop got pop_out=%0d sp=%0d full=%b exp 63 63 0", bus.pop_out, sp, full);
    end
  endtask

  task automatic test_priority();
    int n_push = 0;
    int n_pop = 0;
    logic [SP_W-1:0] sp_before;
    sp_before = sp;
    @(negedge clk);
    bus.push_req = 1'b1;
    bus.pop_req = 1'b1;
    bus.push_data = 16'h0005;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      if (bus.push_done) n_push++;
      if (bus.pop_done) n_pop++;
    end
    bus.push_req = 1'b0;
    bus.pop_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_apply(1'b1, 1'b1, 16'h0005, 1'b0);
    checks++; if (n_push !== 1 || n_pop !== 0) begin errors++; $display("FAIL prio_counts got push=%0d pop=%0d exp 1 0", n_push, n_pop); end
    checks++; if (sp !== SP_W'(sp_before + 1) || sp !== SP_W'(m_q.size())) begin errors++; $display("FAIL prio_sp got %0d exp %0d", sp, m_q.size()); end
  endtask

  task automatic test_reset_mid();
    int lat; bit gp, go, st;
    @(negedge clk);
    bus.push_req = 1'b1;
    bus.push_data = 16'h0099;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    #1;
    bus.push_req = 1'b0;
    checks++; if (sp !== 7'd0 || ovf_err !== 1'b0 || unf_err !== 1'b0) begin
      errors++; $display("FAIL midrst_state got sp=%0d ovf=%b unf=%b exp 0 0 0", sp, ovf_err, unf_err);
    end
    @(posedge clk);
    #1;
    checks++; if (bus.push_done !== 1'b0 || bus.pop_done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b%b exp 00", bus.push_done, bus.pop_done); end
    @(negedge clk);
    rst_b = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    checks++; if (bus.push_done !== 1'b0 || sp !== 7'd0) begin errors++; $display("FAIL midrst_release got done=%b sp=%0d exp 0 0", bus.push_done, sp); end
    run_op(1'b1, 1'b0, 16'h0077, 1'b0, lat, gp, go, st);
    model_apply(1'b1, 1'b0, 16'h0077, 1'b0);
    run_op(1'b0, 1'b1, '0, 1'b0, lat, gp, go, st);
    model_apply(1'b0, 1'b1, '0, 1'b0);
    checks++; if (bus.pop_out !== 16'h0077 || sp !== 7'd0) begin errors++; $display("FAIL midrst_roundtrip got %h sp=%0d exp 0077 0", bus.pop_out, sp); end
  endtask

  task automatic test_random();
    int lat; bit gp, go, st;
    bit push, pop, clr;
    logic [DATA_W-1:0] d;
    int r;
    int bad_state = 0;
    int bad_hs = 0;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      push = (r <= 4) || (r == 9);
      pop = (r >= 5);
      clr = ($urandom_range(0, 7) == 0);
      d = DATA_W'($urandom);
      run_op(push, pop, d, clr, lat, gp, go, st);
      model_apply(push, pop, d, clr);
      if (sp !== SP_W'(m_q.size()) || bus.pop_out !== m_pop_out || ovf_err !== m_ovf ||
          unf_err !== m_unf || empty !== (m_q.size() == 0) || full !== (m_q.size() == DEPTH)) begin
        bad_state++;
        if (bad_state <= 5) $display("FAIL rand_state op %0d got sp=%0d out=%h ovf=%b unf=%b exp sp=%0d out=%h ovf=%b unf=%b",
                                     n, sp, bus.pop_out, ovf_err, unf_err, m_q.size(), m_pop_out, m_ovf, m_unf);
      end
      if (lat != 2 || gp != push || go != (pop && !push) || st != 1'b0) bad_hs++;
    end
    checks++; if (bad_state !== 0) begin errors++; $display("FAIL rand_state_total got %0d bad exp 0", bad_state); end
    checks++; if (bad_hs !== 0) begin errors++; $display("FAIL rand_handshake got %0d bad exp 0", bad_hs); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_underflow();
    test_fill_overflow();
    test_priority();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Hardware LIFO stack that services the push/pop requests issued by the control unit. It is the responder side of the CU's push_data/push_done and pop_out/pop_done interface.
- It owns the stack storage and the stack pointer.
- It returns a one-cycle done pulse per accepted request, so the CU can sequence multi-cycle instructions such as JMP/RET link saves and PUSH/POP.

Parameters:
DATA_W, 16, width of a stack word (matches CU push_data/pop_out)
DEPTH, 64, number of stack entries (power of two not required)
SP_W, 7, stack-pointer width; must hold values 0..DEPTH inclusive

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_b  input  1  asynchronous active-low reset
push_req  input  1  CU push request, level, held until push_done seen
pop_req  input  1  CU pop request, level, held until pop_done seen
push_data  input  DATA_W  word to push, sampled on request acceptance
push_done  output  1  one-cycle pulse: push request completed
pop_done  output  1  one-cycle pulse: pop request completed, pop_out valid
pop_out  output  DATA_W  popped word, held until next successful pop
sp  output  SP_W  current entry count (0 = empty, DEPTH = full)
empty  output  1  sp == 0, combinational from sp
full  output  1  sp == DEPTH, combinational from sp
ovf_err  output  1  sticky: push attempted while full
unf_err  output  1  sticky: pop attempted while empty
err_clr  input  1  synchronous clear of ovf_err/unf_err

Behaviour:
- Reset (rst_b low, asynchronous): state IDLE, sp=0, pop_out=0, push_done=0, pop_done=0, ovf_err=0, unf_err=0. Storage contents are not reset and are don't-care.
- Reset asserted mid-operation aborts the operation. No done pulse follows, and sp keeps the reset value.
- FSM states: IDLE, PUSH, POP, HOLD.
- IDLE:
  - push_req=1 → PUSH; latch push_data into an internal register.
  - else pop_req=1 → POP.
  - Push has priority when both are high. The pop is not serviced and is not flagged.
- PUSH (one cycle):
  - If sp<DEPTH: mem[sp] <= latched data; sp <= sp+1.
  - If sp==DEPTH: no write, sp unchanged, ovf_err <= 1.
  - In either case push_done <= 1 and the next state is HOLD.
- POP (one cycle):
  - If sp>0: pop_out <= mem[sp-1]; sp <= sp-1.
  - If sp==0: pop_out unchanged, sp unchanged, unf_err <= 1.
  - In either case pop_done <= 1 and the next state is HOLD.
- HOLD:
  - push_done and pop_done return to 0 in this cycle; each is high for exactly one cycle.
  - Stay in HOLD while push_req or pop_req is high. Go to IDLE when both are low.
  - This guarantees one operation per request assertion.
- Latency: request sampled high at edge N in IDLE; done and the updated sp/pop_out are visible after edge N+1; the earliest next acceptance is edge N+3, which requires the request to be low at edge N+2.
- Data written at PUSH is readable by a POP accepted in the next request cycle; there are no read-after-write hazards.
- err_clr=1 clears both sticky flags at the edge. If a new error is set in the same cycle, the set wins.
- sp never wraps. Overflow and underflow are blocked and flagged; they never corrupt sp.
- push_data changes after acceptance are ignored.
- Requests arriving while in PUSH, POP or HOLD are not queued.

Test Plan:
- Reset, then push 0x1234, 0xBEEF → each push_done is a single one-cycle pulse two cycles after push_req; sp=2; empty=0.
- Then pop twice → pop_out=0xBEEF then 0x1234; each with a one-cycle pop_done; sp=0; empty=1.
- Pop with sp=0 → pop_done pulses; pop_out keeps 0x1234; unf_err=1; sp=0. Then err_clr=1 for one cycle → unf_err=0.
- Push 64 words 0..63, then push 0xAAAA → full=1 and ovf_err=1 with sp=64. Then pop → pop_out=63.
- push_req and pop_req both high from IDLE with push_data=0x0005 → only the push executes: push_done=1, pop_done stays 0, sp increments by 1. Holding both requests for 5 extra cycles produces no further operations.
- Assert rst_b low during the PUSH state → no push_done, sp=0, all flags 0. After release, a push of 0x0077 followed by a pop returns 0x0077.
